// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin front end that steps a shared external LFSR once per grant,
// returns the fresh value with an ack and clears the LFSR on all-zero lockup. Optional macro: LFSR_WARMUP_EN.
`default_nettype none

module lfsr_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int WARMUP = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic             ack,
    output logic [WIDTH-1:0] rnd_data,
    output logic             lfsr_en,
    output logic             lfsr_clr,
    input  logic [WIDTH-1:0] lfsr_value,
    output logic             ready,
    output logic             stuck
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_WARM  = 3'd0,
        S_IDLE  = 3'd1,
        S_STEP  = 3'd2,
        S_LATCH = 3'd3,
        S_CLR   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

`ifdef LFSR_WARMUP_EN
    localparam state_t RESET_STATE = S_WARM;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]  rnd_q, rnd_d;
    logic              stuck_q, stuck_d;
    logic              en_q, clr_q, ack_q, ready_q;
`ifdef LFSR_WARMUP_EN
    logic [7:0]        cnt_q, cnt_d;
`endif

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    int                idx;

    // Cyclic search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        idx       = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        rnd_d   = rnd_q;
        stuck_d = stuck_q;
`ifdef LFSR_WARMUP_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_WARM: begin
`ifdef LFSR_WARMUP_EN
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_IDLE: begin
                if (win_found) begin
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    ptr_d   = win_idx;
                    state_d = S_STEP;
                end
            end
            S_STEP:  state_d = S_LATCH;
            S_LATCH: begin
                if (lfsr_value != '0) begin
                    rnd_d   = lfsr_value;
                    state_d = S_DONE;
                end else begin
                    stuck_d = 1'b1;
                    state_d = S_CLR;
                end
            end
            S_CLR:   state_d = S_STEP;
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they read 0 while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(NREQ - 1);
            rnd_q   <= '0;
            stuck_q <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
`ifdef LFSR_WARMUP_EN
            cnt_q   <= 8'(WARMUP);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            rnd_q   <= rnd_d;
            stuck_q <= stuck_d;
            en_q    <= (state_d == S_STEP) || (state_d == S_WARM);
            clr_q   <= (state_d == S_CLR);
            ack_q   <= (state_d == S_DONE);
            ready_q <= (state_d == S_IDLE);
`ifdef LFSR_WARMUP_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign ack      = ack_q;
    assign rnd_data = rnd_q;
    assign lfsr_en  = en_q;
    assign lfsr_clr = clr_q;
    assign ready    = ready_q;
    assign stuck    = stuck_q;

endmodule

`default_nettype wire

// File: doc/lfsr_arbiter.md
Name: lfsr_arbiter

Overview:
Controller that shares one external 8-bit LFSR between NREQ requesters.
- Round-robin arbitrates the req lines.
- Steps the LFSR exactly once per granted transaction and returns the fresh value with a one-cycle ack.
- Detects the all-zero lockup state and clears the LFSR.
- Sits between the lfsr instance (drives its enable and reset inputs, reads its value) and the consumer blocks.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, LFSR value width
WARMUP, 16, enable cycles issued after reset when LFSR_WARMUP_EN is defined (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; low forces every register to its reset value
req  input  NREQ  per-requester request, level
grant  output  NREQ  one-hot grant, held for the whole transaction; reset 0
ack  output  1  one-cycle pulse, rnd_data valid for granted requester; reset 0
rnd_data  output  WIDTH  captured LFSR value, holds until next capture; reset 0
lfsr_en  output  1  step enable to lfsr; reset 0
lfsr_clr  output  1  active-high one-cycle reset pulse to lfsr; reset 0
lfsr_value  input  WIDTH  current lfsr output
ready  output  1  high when arbiter accepts requests (state IDLE); reset 0
stuck  output  1  sticky flag, set on any zero lockup, cleared only by reset; reset 0

Behaviour:
- States: WARM, IDLE, STEP, LATCH, CLR, DONE. Reset state is IDLE (WARM with feature).
- All outputs are registered or pure decodes of the state register:
  - lfsr_en = STEP or WARM
  - lfsr_clr = CLR
  - ack = DONE
  - ready = IDLE
- IDLE, req != 0 sampled at edge k:
  - Pick the winner by searching from ptr+1 cyclically.
  - grant<=onehot(winner), ptr<=winner, go STEP.
- IDLE, req == 0: stay; grant stays 0.
- STEP: lfsr_en high for exactly one cycle; go LATCH. The lfsr updates on the edge ending STEP.
- LATCH, lfsr_value != 0: rnd_data<=lfsr_value, go DONE.
- LATCH, lfsr_value == 0: stuck<=1, go CLR; rnd_data unchanged.
- CLR: lfsr_clr high one cycle, go STEP (retry with the same grant). There is no retry limit.
- DONE: ack=1 with grant still asserted; go IDLE, grant<=0.
- Latency, no lockup: req sampled at edge k → grant high from cycle k+1, ack in cycle k+3; 4 cycles per transaction including the IDLE cycle.
- Each lockup retry adds 3 cycles.
- ptr reset value is NREQ-1, so req[0] wins first.
- Requests arriving during a transaction wait; there is no preemption.
- req dropping mid-transaction is ignored; the transaction completes and ack still fires.
- Several req bits high in IDLE: only one grant, chosen by round-robin; the others are served in subsequent transactions in rotation order.
- Reset asserted mid-transaction: immediate return to reset values; no ack; pending transaction lost; ptr back to NREQ-1.
- lfsr_en and lfsr_clr are never high in the same cycle.

Optional Feature:
LFSR_WARMUP_EN:
- Defined:
  - After reset release, enter WARM.
  - Assert lfsr_en for WARMUP consecutive cycles (8-bit down counter); ready=0 and req ignored.
  - Then go IDLE.
  - A zero lfsr_value during WARM is not checked.
- Undefined:
  - No WARM state or counter; IDLE directly after reset.
  - ready=1 in the first cycle after reset release.

Test Plan:
- Reset: reset=0 with req=4'b1111 → grant=0, ack=0, lfsr_en=0, lfsr_clr=0, stuck=0, rnd_data=0. Release → ready=1 next cycle (feature off).
- Single request, req=4'b0100 held, bench lfsr model returns 8'hA5 after the step → grant=4'b0100 for 3 cycles, one lfsr_en pulse, ack 3 cycles after the sampled req, rnd_data=8'hA5.
- Round-robin, req=4'b1111 held continuously → grants in order 0001, 0010, 0100, 1000, 0001, one every 4 cycles; exactly 5 lfsr_en pulses and 5 acks in 20 cycles.
- Lockup, bench returns 8'h00 on the first step and 8'h3C after clear → sequence STEP, LATCH, CLR (lfsr_clr 1 cycle), STEP, LATCH, DONE; stuck=1 and stays 1; rnd_data=8'h3C; a single ack.
- Mid-transaction events: drop req the cycle after grant → ack still issued. Separately, assert reset during LATCH → no ack, grant=0 immediately, next grant goes to the lowest active req.
- Feature on, WARMUP=16 → lfsr_en high for exactly 16 cycles after reset release, ready=0 throughout, req=4'b0001 not granted until ready=1.
